ram_arbiter: RTL and testbench

Shares the single-port 4-bit data RAM between the uP core (address_RAM / cs / we path) and a host debug/loader port.
- Sits between the core's RAM control signals and the RAM instance.
- The core has priority by default; a starvation guard bounds host wait by stalling the core.
- Host side uses a req/done handshake with registered read data.

---
 rtl/ram_arbiter.sv | 59 +++++
 tb/tb_ram_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port data RAM between the core and a host req/done port.
// Define ARB_STARVE_GUARD_EN to let a starving host stall the core after MAX_WAIT cycles.
module ram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 4,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              core_cs,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_done,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  typedef enum logic {IDLE, DONE} state_t;
  state_t state, state_nxt;
  logic host_grant, force_grant;
`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] wait_cnt;
  assign force_grant = wait_cnt == 4'(MAX_WAIT);
  assign core_stall = host_grant && core_cs;
  always_ff @(posedge clock or negedge reset)
    if (!reset) wait_cnt <= '0;
    else if (state == IDLE)
      wait_cnt <= (host_grant || !host_req) ? 4'd0 : force_grant ? wait_cnt : wait_cnt + 4'd1;
`else
  assign force_grant = 1'b0;
  assign core_stall = 1'b0;
`endif
  assign host_grant = state == IDLE && host_req && (!core_cs || force_grant);
  assign host_done = state == DONE;
  assign core_rdata = ram_rdata;
  assign ram_cs = host_grant || core_cs;
  assign ram_we = host_grant ? host_we : core_we;
  assign ram_addr = host_grant ? host_addr : core_addr;
  assign ram_wdata = host_grant ? host_wdata : core_wdata;
  always_comb state_nxt = (state == IDLE && host_grant) ? DONE : IDLE;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      host_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (host_grant && !host_we) host_rdata <= ram_rdata;
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and randomized checks of ram_arbiter against a transaction-level model.
module tb_ram_arbiter;
  localparam int AW = 12, DW = 4, MW = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clock = 0, reset = 0;
  logic core_cs = 0, core_we = 0, host_req = 0, host_we = 0;
  logic [AW-1:0] core_addr = '0, host_addr = '0;
  logic [DW-1:0] core_wdata = '0, host_wdata = '0;
  logic [DW-1:0] core_rdata, host_rdata, ram_wdata, ram_rdata;
  logic core_stall, host_done, ram_cs, ram_we;
  logic [AW-1:0] ram_addr;
  int checks = 0, failures = 0;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] em  [0:(1<<AW)-1];
  logic m_done;
  int m_wait;
  logic [DW-1:0] m_rdata;
  logic m_grant;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clock(clock), .reset(reset), .core_cs(core_cs), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_stall(core_stall), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_done(host_done), .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));

  always #5 clock = ~clock;

  // the actual RAM behind the arbiter
  assign ram_rdata = mem[ram_addr];
  always @(posedge clock) if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;

  // transaction-level reference: host served when RAM is free or after MAX_WAIT waits
  assign m_grant = !m_done && host_req && (!core_cs || (GUARD && m_wait >= MW));
  always @(posedge clock or negedge reset)
    if (!reset) begin
      m_done <= 0; m_wait <= 0; m_rdata <= '0;
    end else if (m_grant) begin
      m_done <= 1; m_wait <= 0;
      if (host_we) em[host_addr] <= host_wdata; else m_rdata <= em[host_addr];
    end else begin
      m_done <= 0;
      if (!m_done) m_wait <= host_req ? (m_wait < MW ? m_wait + 1 : m_wait) : 0;
      if (core_cs && core_we) em[core_addr] <= core_wdata;
    end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic idle();
    core_cs = 0; core_we = 0; host_req = 0; host_we = 0;
    tick(); tick();
  endtask

  task automatic test_reset();
    host_req = 1; host_we = 1; host_addr = 12'h050; host_wdata = 4'h3;
    tick();
    host_we = 0;
    tick(); tick();
    checks++;
    if (host_done !== 1'b1 || host_rdata !== 4'h3) begin
      failures++; $display("FAIL reset_pre: done=%b rdata=%h need 1/3", host_done, host_rdata);
    end
    reset = 0; host_req = 0; #1;
    checks++;
    if (host_done !== 1'b0 || host_rdata !== 4'h0 || core_stall !== 1'b0) begin
      failures++; $display("FAIL reset_async: done=%b rdata=%h stall=%b need 0/0/0", host_done, host_rdata, core_stall);
    end
    tick();
    reset = 1; core_cs = 1; core_addr = 12'h005;
    @(negedge clock);
    checks++;
    if (ram_addr !== 12'h005 || ram_cs !== 1'b1 || host_done !== 1'b0) begin
      failures++; $display("FAIL reset_release: addr=%h cs=%b done=%b need 005/1/0", ram_addr, ram_cs, host_done);
    end
    tick(); idle();
  endtask

  task automatic test_idle_write_read();
    host_req = 1; host_we = 1; host_addr = 12'h123; host_wdata = 4'hA;
    @(negedge clock);
    checks++;
    if (ram_we !== 1'b1 || ram_cs !== 1'b1 || ram_addr !== 12'h123 || ram_wdata !== 4'hA || host_done !== 1'b0) begin
      failures++; $display("FAIL idle_write: we=%b cs=%b addr=%h wd=%h done=%b", ram_we, ram_cs, ram_addr, ram_wdata, host_done);
    end
    tick();
    host_we = 0;
    @(negedge clock);
    checks++;
    if (host_done !== 1'b1 || ram_cs !== 1'b0) begin
      failures++; $display("FAIL idle_write_done: done=%b cs=%b need 1/0", host_done, ram_cs);
    end
    tick();
    @(negedge clock);
    checks++;
    if (ram_we !== 1'b0 || ram_addr !== 12'h123 || ram_cs !== 1'b1) begin
      failures++; $display("FAIL idle_read: we=%b addr=%h cs=%b", ram_we, ram_addr, ram_cs);
    end
    tick();
    host_req = 0;
    @(negedge clock);
    checks++;
    if (host_done !== 1'b1 || host_rdata !== 4'hA) begin
      failures++; $display("FAIL idle_read_data: done=%b rdata=%h need 1/a", host_done, host_rdata);
    end
    tick(); idle();
  endtask

  task automatic test_core_priority();
    core_cs = 1; core_addr = 12'h777; host_req = 1; host_we = 0; host_addr = 12'h123;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      checks++;
      if (ram_addr !== 12'h777 || core_stall !== 1'b0 || host_done !== 1'b0) begin
        failures++; $display("FAIL prio_core c%0d: addr=%h stall=%b done=%b", c, ram_addr, core_stall, host_done);
      end
      tick();
    end
    core_cs = 0;
    @(negedge clock);
    checks++;
    if (ram_addr !== 12'h123 || ram_cs !== 1'b1 || host_done !== 1'b0) begin
      failures++; $display("FAIL prio_grant: addr=%h cs=%b done=%b need 123/1/0", ram_addr, ram_cs, host_done);
    end
    tick();
    host_req = 0;
    @(negedge clock);
    checks++;
    if (host_done !== 1'b1 || host_rdata !== 4'hA || core_stall !== 1'b0) begin
      failures++; $display("FAIL prio_done: done=%b rdata=%h stall=%b need 1/a/0", host_done, host_rdata, core_stall);
    end
    tick(); idle();
  endtask

`ifdef ARB_STARVE_GUARD_EN
  task automatic test_starvation();
    core_cs = 1; core_addr = 12'h0F0; host_req = 1; host_we = 0; host_addr = 12'h123;
    for (int c = 1; c <= MW + 2; c++) begin
      @(negedge clock);
      checks++;
      if (core_stall !== (c == MW + 1) || ram_addr !== (c == MW + 1 ? 12'h123 : 12'h0F0) || host_done !== (c == MW + 2)) begin
        failures++; $display("FAIL starve c%0d: stall=%b addr=%h done=%b", c, core_stall, ram_addr, host_done);
      end
      tick();
      if (c == MW + 1) host_req = 0;
    end
    idle();
  endtask
`else
  task automatic test_guard_off();
    int bad = 0;
    core_cs = 1; core_addr = 12'h0F0; host_req = 1; host_we = 0; host_addr = 12'h123;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (host_done !== 1'b0 || core_stall !== 1'b0 || ram_addr !== 12'h0F0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL guard_off_hold: %0d bad cycles, need 0", bad);
    end
    core_cs = 0;
    @(negedge clock);
    checks++;
    if (ram_addr !== 12'h123 || host_done !== 1'b0) begin
      failures++; $display("FAIL guard_off_grant: addr=%h done=%b need 123/0", ram_addr, host_done);
    end
    tick();
    host_req = 0;
    @(negedge clock);
    checks++;
    if (host_done !== 1'b1) begin
      failures++; $display("FAIL guard_off_done: done=%b need 1", host_done);
    end
    tick(); idle();
  endtask
`endif

  task automatic test_back_to_back();
    logic [DW-1:0] want [3];
    for (int i = 0; i < 3; i++) begin
      want[i] = DW'($urandom);
      em[12'h200 + i] = want[i]; mem[12'h200 + i] = want[i];
    end
    host_req = 1; host_we = 0; host_addr = 12'h200;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      checks++;
      if (host_done !== c[0] || ram_cs !== !c[0] || (c[0] && host_rdata !== want[c/2])) begin
        failures++; $display("FAIL b2b c%0d: done=%b cs=%b rdata=%h need %b/%b/%h",
          c, host_done, ram_cs, host_rdata, c[0], !c[0], want[c/2]);
      end
      tick();
      if (c[0]) host_addr = host_addr + 1;
      if (c == 4) host_req = 0;
    end
    idle();
  endtask

  task automatic test_random();
    logic [AW-1:0] ea;
    for (int c = 0; c < 600; c++) begin
      core_cs = ($urandom_range(0, 3) != 0); core_we = $urandom_range(0, 1);
      core_addr = AW'($urandom_range(0, 15)); core_wdata = DW'($urandom);
      if (!host_req || m_done) begin
        host_req = ($urandom_range(0, 2) != 0); host_we = $urandom_range(0, 1);
        host_addr = AW'($urandom_range(0, 15)); host_wdata = DW'($urandom);
      end
      @(negedge clock);
      ea = m_grant ? host_addr : core_addr;
      checks++;
      if (ram_cs !== (m_grant || core_cs) || ram_addr !== ea ||
          ram_we !== (m_grant ? host_we : core_we) || ram_wdata !== (m_grant ? host_wdata : core_wdata)) begin
        failures++; $display("FAIL rand_mux c%0d: cs=%b addr=%h we=%b wd=%h need %b/%h", c, ram_cs, ram_addr, ram_we, ram_wdata, m_grant || core_cs, ea);
      end
      checks++;
      if (core_stall !== (m_grant && core_cs) || host_done !== m_done || core_rdata !== em[ea]) begin
        failures++; $display("FAIL rand_ctl c%0d: stall=%b done=%b crd=%h need %b/%b/%h", c, core_stall, host_done, core_rdata, m_grant && core_cs, m_done, em[ea]);
      end
      if (m_done) begin
        checks++;
        if (host_rdata !== m_rdata) begin
          failures++; $display("FAIL rand_rdata c%0d: rdata=%h need %h", c, host_rdata, m_rdata);
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin mem[i] = '0; em[i] = '0; end
    #1;
    checks++;
    if (host_done !== 1'b0 || host_rdata !== 4'h0 || core_stall !== 1'b0 || ram_cs !== 1'b0) begin
      failures++; $display("FAIL reset_state: done=%b rdata=%h stall=%b cs=%b", host_done, host_rdata, core_stall, ram_cs);
    end
    tick(); tick();
    reset = 1;
    tick();
    test_reset();
    test_idle_write_read();
    test_core_priority();
`ifdef ARB_STARVE_GUARD_EN
    test_starvation();
`else
    test_guard_off();
`endif
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
